// File: rtl/solve_dispatcher.sv
// Job feeder for the endgame solver: queues boards, runs them one at a time,
// rejects overlapping boards and aborts solves that exceed TIMEOUT cycles.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for a queued job; pops and classifies the FIFO head
//   S_SOLVE | oEnable high, counting cycles until solved or timeout
//   S_DONE  | result presented on the valid/ready port
module solve_dispatcher #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 8,
   parameter int TIMEOUT = 10000000,
   parameter int CNT_W   = 32
) (
   input  logic                    iCLOCK,
   input  logic                    iRESET,
   input  logic                    iBoardValid,
   output logic                    oBoardReady,
   input  logic [63:0]             iBoardPlayer,
   input  logic [63:0]             iBoardOpponent,
   input  logic [TAG_W-1:0]        iBoardTag,
   output logic                    oEnable,
   output logic [63:0]             oPlayer,
   output logic [63:0]             oOpponent,
   input  logic                    iSolved,
   input  logic signed [7:0]       iRes,
   output logic                    oResValid,
   input  logic                    iResReady,
   output logic signed [7:0]       oRes,
   output logic [TAG_W-1:0]        oResTag,
   output logic [1:0]              oResErr,
   output logic [CNT_W-1:0]        oCycles,
   output logic                    oBusy
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SOLVE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT);
   localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);

   logic [63:0]      fifo_p_q [DEPTH];
   logic [63:0]      fifo_o_q [DEPTH];
   logic [TAG_W-1:0] fifo_t_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             rdy_en_q;

   logic [1:0]       state_q, state_d;
   logic             en_q, en_d;
   logic [63:0]      player_q, player_d, opp_q, opp_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cyc_q, cyc_d;
   logic signed [7:0] res_q, res_d;
   logic [1:0]       err_q, err_d;
   logic             push, pop, full;

   assign full        = (count_q == FULL_CNT);
   // rdy_en_q keeps ready low during reset and for the reset edge itself
   assign oBoardReady = rdy_en_q & ~full;
   assign push        = iBoardValid & oBoardReady;

   always_comb begin
      state_d  = state_q;
      en_d     = en_q;
      player_d = player_q;
      opp_d    = opp_q;
      tag_d    = tag_q;
      cnt_d    = cnt_q;
      cyc_d    = cyc_q;
      res_d    = res_q;
      err_d    = err_q;
      pop      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop      = 1'b1;
               player_d = fifo_p_q[rd_ptr_q];
               opp_d    = fifo_o_q[rd_ptr_q];
               tag_d    = fifo_t_q[rd_ptr_q];
               if ((fifo_p_q[rd_ptr_q] & fifo_o_q[rd_ptr_q]) != 64'd0) begin
                  state_d = S_DONE;
                  err_d   = 2'd1;
                  res_d   = '0;
                  cyc_d   = '0;
               end else begin
                  state_d = S_SOLVE;
                  en_d    = 1'b1;
                  cnt_d   = '0;
               end
            end
         end
         S_SOLVE: begin
            cnt_d = cnt_q + CNT_ONE;
            if (iSolved) begin
               res_d   = iRes;
               cyc_d   = cnt_q + CNT_ONE;
               err_d   = 2'd0;
               en_d    = 1'b0;
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               res_d   = '0;
               cyc_d   = CNT_TO;
               err_d   = 2'd2;
               en_d    = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (iResReady) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLOCK) begin
      if (push) begin
         fifo_p_q[wr_ptr_q] <= iBoardPlayer;
         fifo_o_q[wr_ptr_q] <= iBoardOpponent;
         fifo_t_q[wr_ptr_q] <= iBoardTag;
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (iRESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdy_en_q <= 1'b0;
         state_q  <= S_IDLE;
         en_q     <= 1'b0;
         player_q <= '0;
         opp_q    <= '0;
         tag_q    <= '0;
         cnt_q    <= '0;
         cyc_q    <= '0;
         res_q    <= '0;
         err_q    <= '0;
      end else begin
         rdy_en_q <= 1'b1;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         state_q  <= state_d;
         en_q     <= en_d;
         player_q <= player_d;
         opp_q    <= opp_d;
         tag_q    <= tag_d;
         cnt_q    <= cnt_d;
         cyc_q    <= cyc_d;
         res_q    <= res_d;
         err_q    <= err_d;
      end
   end

   assign oEnable   = en_q;
   assign oPlayer   = player_q;
   assign oOpponent = opp_q;
   assign oResValid = (state_q == S_DONE);
   assign oRes      = res_q;
   assign oResTag   = tag_q;
   assign oResErr   = err_q;
   assign oCycles   = cyc_q;
   assign oBusy     = (state_q != S_IDLE) | (count_q != '0);
endmodule
